display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single 4-digit segment driver between NUM_REQ clients.
- Clients include, for example, a value display, a status display and a debug display.
- Each client raises a request with four segment-encoded digits. The arbiter picks one winner, latches its digits, and strobes the driver. It then tracks driver busy through the frame and returns done/error to the winner.
- It sits between the client logic and the driver instance, in place of a free-running strobe.

Parameters:
- NUM_REQ, 3, number of clients (2..8).
- GAP_CYCLES, 4000, idle cycles enforced after each frame before the next grant.
- START_TIMEOUT, 255, max cycles in ISSUE waiting for drv_busy_i to rise before aborting.

Ports:
- clk_i  input  1  system clock
- porb_i  input  1  asynchronous active-low reset
- req_i  input  NUM_REQ  per-client frame request (level)
- digits_i  input  NUM_REQ x 4 x 8  per-client segment patterns, digit 0 first
- gnt_o  output  NUM_REQ  one-hot grant, held for the whole transaction
- done_o  output  NUM_REQ  one-cycle pulse to the granted client at frame end
- err_o  output  NUM_REQ  one-cycle pulse, coincident with done_o, on ack error or start timeout
- drv_digits_o  output  4 x 8  latched patterns to the driver
- drv_strobe_o  output  1  frame start request to the driver
- drv_busy_i  input  1  driver busy
- drv_ack_error_i  input  1  driver ack-error flag
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: single clock clk_i; asynchronous active-low reset porb_i. All outputs, the state and the counters clear asynchronously to 0. The state goes to IDLE. The RR pointer resets to NUM_REQ-1, so client 0 has first priority. Reset mid-frame aborts silently: no done/err is issued.
- States: IDLE, ISSUE, WAIT_DONE, GAP. All outputs are registered.
- IDLE:
  - If req_i != 0, pick the first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Next cycle: gnt_o is one-hot for the winner, drv_digits_o is loaded from that client's digits_i, the pointer is set to the winner, and the state is ISSUE.
  - Grant latency is 1 cycle from a req in IDLE.
- ISSUE:
  - drv_strobe_o=1.
  - When drv_busy_i=1: drv_strobe_o drops the next cycle and the state goes to WAIT_DONE.
  - If START_TIMEOUT cycles elapse with busy never seen: drop the strobe, pulse done_o and err_o for the winner, and go to GAP.
- WAIT_DONE:
  - drv_strobe_o=0. A sticky err flag ORs in drv_ack_error_i each cycle.
  - On drv_busy_i=0: pulse done_o, plus err_o if the sticky flag is set. Clear gnt_o in the same cycle and go to GAP.
- GAP:
  - Counter runs 0..GAP_CYCLES-1, then the state goes to IDLE.
  - Requests are ignored during GAP. GAP_CYCLES=0 means a direct return to IDLE.
- Data stability: drv_digits_o changes only on the IDLE->ISSUE transition. Client digits_i changing after the grant has no effect.
- Request withdrawn after grant: the transaction completes normally and done_o still pulses.
- Simultaneous requests: resolved strictly round-robin. A client holding req_i continuously cannot win twice in a row if another client requests.
- Request held through done: the client is re-eligible at the next IDLE, subject to RR order.
- drv_busy_i already high on entry to ISSUE: treated as started. One strobe cycle is still issued.
- Counter widths: $clog2(GAP_CYCLES+1) and $clog2(START_TIMEOUT+1). Both saturate at their limit; neither wraps.

Decomposition:
- Package display_pkg:
  - state_t enum.
  - seg_frame_t typedef (logic [3:0][7:0]).
  - the segment-code constants already used by the display path.
- One sub-module, rr_arbiter.
  - Parameter: NUM_REQ.
  - Inputs: req, pointer. Output: one-hot gnt.
  - Purely combinational priority rotate.
- FSM, counters and registers stay in display_arbiter.

Test Plan:
- Single request: after reset, req_i=3'b001 with digits 0x3F,0x06,0x5B,0x4F. Required: gnt_o=001 on the next cycle, drv_digits_o matches, strobe high until the driver-model busy rises, done_o[0] pulses exactly once when busy falls, err_o=0.
- Round robin: req_i=3'b111 held constantly. Required: grant order 0,1,2,0 across frames, with at least GAP_CYCLES idle cycles between done_o and the next gnt_o.
- Ack error: the driver model asserts drv_ack_error_i for 1 cycle mid-frame for client 1. Required: done_o[1] and err_o[1] pulse together; the next frame from client 1 has err_o=0.
- Start timeout: the driver model never raises busy. Required: strobe drops after 255 cycles, done_o and err_o pulse, return to IDLE after GAP.
- Data stability: client 2 changes digits_i, then drops req_i, one cycle after its grant. Required: drv_digits_o holds the original pattern and done_o[2] still pulses.
- Reset mid-frame: deassert porb_i during WAIT_DONE. Required: all outputs are 0 immediately, with no done pulse. After release, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter and its clients.
package display_pkg;

  // Arbiter FSM states; encoding is visible on the state debug output.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  // Four segment-encoded digits, digit 0 in the lowest byte.
  typedef logic [3:0][7:0] seg_frame_t;

  // Segment codes (bit 0 = segment a ... bit 6 = segment g, bit 7 = dp).
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Index of the set bit in a one-hot vector of up to 8 clients.
  function automatic int unsigned onehot_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] idx;

  // Scan farthest-to-nearest so the nearest requester after the pointer wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = PTR_W'((int'(pointer) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter and sequencer sharing one 4-digit segment driver.
//
// Driver handshake: the arbiter holds drv_strobe_o high in ISSUE until it
// samples drv_busy_i high (the driver has accepted the frame); the frame is
// over when drv_busy_i is sampled low in WAIT_DONE. drv_digits_o is stable
// from the grant until the next grant. The client side is a level request:
// gnt_o is held for the whole transaction and done_o/err_o pulse once.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int GAP_CYCLES    = 4000,
  parameter int START_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  porb_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*32-1:0] digits_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic [31:0]           drv_digits_o,
  output logic                  drv_strobe_o,
  input  logic                  drv_busy_i,
  input  logic                  drv_ack_error_i,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (START_TIMEOUT > 0) ? $clog2(START_TIMEOUT + 1) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(START_TIMEOUT);

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               err_sticky;
  logic [NUM_REQ-1:0] win_gnt;
  logic [PTR_W-1:0]   win_idx;
  seg_frame_t         win_digits;
  logic               to_expired;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (req_i),
    .pointer (ptr),
    .gnt     (win_gnt)
  );

  assign win_idx    = PTR_W'(onehot_to_idx(8'(win_gnt)));
  assign to_expired = (START_TIMEOUT == 0) || (to_cnt >= TO_LAST);
  assign state_o    = state;

  // Select the winning client's digit pattern for latching at grant time.
  always_comb begin
    win_digits = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_gnt[k]) win_digits = digits_i[k*32 +: 32];
    end
  end

  // Transaction FSM with registered outputs, counters and RR pointer.
  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      state        <= ST_IDLE;
      ptr          <= PTR_W'(NUM_REQ - 1);
      gnt_o        <= '0;
      done_o       <= '0;
      err_o        <= '0;
      drv_digits_o <= '0;
      drv_strobe_o <= 1'b0;
      busy_o       <= 1'b0;
      err_sticky   <= 1'b0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        ST_IDLE: begin
          if (req_i != '0) begin
            gnt_o        <= win_gnt;
            drv_digits_o <= win_digits;
            ptr          <= win_idx;
            drv_strobe_o <= 1'b1;
            busy_o       <= 1'b1;
            err_sticky   <= 1'b0;
            to_cnt       <= '0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (drv_busy_i) begin
            drv_strobe_o <= 1'b0;
            state        <= ST_WAIT_DONE;
          end else if (to_expired) begin
            // Driver never started: abort the frame with an error.
            drv_strobe_o <= 1'b0;
            done_o       <= gnt_o;
            err_o        <= gnt_o;
            gnt_o        <= '0;
            gap_cnt      <= '0;
            if (GAP_CYCLES == 0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          err_sticky <= err_sticky | drv_ack_error_i;
          if (!drv_busy_i) begin
            done_o  <= gnt_o;
            err_o   <= (err_sticky | drv_ack_error_i) ? gnt_o : '0;
            gnt_o   <= '0;
            gap_cnt <= '0;
            if (GAP_CYCLES == 0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_LAST) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with a behavioural driver model.
module tb_display_arbiter;
  import display_pkg::*;

  localparam int N   = 3;
  localparam int GAP = 16;
  localparam int TMO = 255;

  logic            clk = 1'b0;
  logic            porb = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*32-1:0] digits = '0;
  logic [N-1:0]    gnt_o, done_o, err_o;
  logic [31:0]     drv_digits_o;
  logic            drv_strobe_o;
  logic            drv_busy = 1'b0;
  logic            drv_ack_err = 1'b0;
  logic            busy_o;
  logic [1:0]      state_o;

  int tests_run = 0;
  int fails = 0;
  int done_pulses = 0;

  // Driver model knobs.
  int busy_delay = 1;
  int busy_len   = 4;
  int err_at     = -1;
  bit never_busy = 1'b0;

  // Scoreboards: expected grants {gnt, digits} and frame results {err, done}.
  logic [N+31:0]  exp_gnt_q[$];
  logic [2*N-1:0] exp_q[$];

  display_arbiter #(
    .NUM_REQ       (N),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (TMO)
  ) dut (
    .clk_i           (clk),
    .porb_i          (porb),
    .req_i           (req),
    .digits_i        (digits),
    .gnt_o           (gnt_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .drv_digits_o    (drv_digits_o),
    .drv_strobe_o    (drv_strobe_o),
    .drv_busy_i      (drv_busy),
    .drv_ack_error_i (drv_ack_err),
    .busy_o          (busy_o),
    .state_o         (state_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver model: accepts a strobe after busy_delay cycles, stays busy busy_len cycles.
  initial begin : driver_model
    forever begin
      @(negedge clk);
      if (porb && drv_strobe_o && !never_busy) begin
        for (int d = 0; d < busy_delay && porb; d++) @(negedge clk);
        if (porb) begin
          drv_busy = 1'b1;
          for (int c = 0; c < busy_len && porb; c++) begin
            drv_ack_err = (c == err_at);
            @(negedge clk);
          end
        end
        drv_busy    = 1'b0;
        drv_ack_err = 1'b0;
      end
    end
  end

  // Monitor: compares each new grant and each done/err pulse against the queues.
  initial begin : monitor
    logic [N-1:0]   prev_gnt;
    logic [N+31:0]  eg;
    logic [2*N-1:0] ed;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (porb) begin
        if (gnt_o != '0 && prev_gnt == '0) begin
          tests_run++;
          if (exp_gnt_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_grant: got gnt=%b digits=%h, none expected", gnt_o, drv_digits_o);
          end else begin
            eg = exp_gnt_q.pop_front();
            if ({gnt_o, drv_digits_o} !== eg) begin
              fails++;
              $display("FAIL grant: got gnt=%b digits=%h, expected gnt=%b digits=%h",
                       gnt_o, drv_digits_o, eg[N+31:32], eg[31:0]);
            end
          end
        end
        if (done_o != '0 || err_o != '0) begin
          done_pulses++;
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: got done=%b err=%b, none expected", done_o, err_o);
          end else begin
            ed = exp_q.pop_front();
            if ({err_o, done_o} !== ed) begin
              fails++;
              $display("FAIL frame_result: got done=%b err=%b, expected done=%b err=%b",
                       done_o, err_o, ed[N-1:0], ed[2*N-1:N]);
            end
          end
        end
      end
      prev_gnt = gnt_o;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    porb = 1'b0;
    req  = '0;
    repeat (3) @(negedge clk);
    porb = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy_o=%b after %0d cycles, expected 0", name, busy_o, max);
    end
  endtask

  // One complete frame from client c with only that client requesting.
  task automatic run_frame(input string name, input int c, input logic [31:0] pat, input bit exp_err);
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << c;
    digits[c*32 +: 32] = pat;
    exp_gnt_q.push_back({oh, pat});
    exp_q.push_back({exp_err ? oh : {N{1'b0}}, oh});
    req = oh;
    n = 0;
    while (gnt_o !== oh && n < 5) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (gnt_o !== oh) begin
      fails++;
      $display("FAIL %s_grant: got gnt=%b, expected %b", name, gnt_o, oh);
    end
    req = '0;
    n = 0;
    while (done_o === '0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (done_o !== oh) begin
      fails++;
      $display("FAIL %s_done: got done=%b, expected %b", name, done_o, oh);
    end
    wait_idle({name, "_idle"}, GAP + 5);
  endtask

  task automatic test_reset();
    porb = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({gnt_o, done_o, err_o, drv_digits_o, drv_strobe_o, busy_o, state_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b digits=%h strobe=%b busy=%b state=%0d, expected all 0",
               gnt_o, done_o, err_o, drv_digits_o, drv_strobe_o, busy_o, state_o);
    end
    porb = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || gnt_o !== '0) begin
      fails++;
      $display("FAIL idle_no_req: busy=%b gnt=%b, expected 0/000", busy_o, gnt_o);
    end
  endtask

  task automatic test_single();
    int strobe_cnt;
    int d0;
    bit seen;
    logic [31:0] pat;
    pat = {SEG_3, SEG_2, SEG_1, SEG_0};
    busy_delay = 3;
    busy_len   = 5;
    err_at     = -1;
    strobe_cnt = 0;
    seen       = 1'b0;
    d0         = done_pulses;
    digits[31:0] = pat;
    exp_gnt_q.push_back({3'b001, pat});
    exp_q.push_back({3'b000, 3'b001});
    req = 3'b001;
    @(negedge clk);
    tests_run++;
    if (gnt_o !== 3'b001) begin
      fails++;
      $display("FAIL single_latency: got gnt=%b one cycle after req, expected 001", gnt_o);
    end
    tests_run++;
    if (drv_digits_o !== 32'h4F5B063F) begin
      fails++;
      $display("FAIL single_digits: got %h, expected 4f5b063f", drv_digits_o);
    end
    req = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (drv_strobe_o) strobe_cnt++;
      if (done_o != '0) seen = 1'b1;
      else @(negedge clk);
    end
    tests_run++;
    if (strobe_cnt != busy_delay + 1) begin
      fails++;
      $display("FAIL single_strobe: strobe high %0d cycles, expected %0d", strobe_cnt, busy_delay + 1);
    end
    wait_idle("single_idle", GAP + 5);
    repeat (5) @(negedge clk);
    tests_run++;
    if (done_pulses - d0 != 1) begin
      fails++;
      $display("FAIL single_done_count: got %0d done pulses, expected 1", done_pulses - d0);
    end
  endtask

  task automatic test_round_robin();
    int cyc, ndone, ngnt, last_done;
    logic [N-1:0] pg;
    do_reset();
    busy_delay = 1;
    busy_len   = 3;
    err_at     = -1;
    digits = {SEG_2, SEG_2, SEG_2, SEG_2, SEG_1, SEG_1, SEG_1, SEG_1, SEG_0, SEG_0, SEG_0, SEG_0};
    exp_gnt_q.push_back({3'b001, {4{SEG_0}}});
    exp_gnt_q.push_back({3'b010, {4{SEG_1}}});
    exp_gnt_q.push_back({3'b100, {4{SEG_2}}});
    exp_gnt_q.push_back({3'b001, {4{SEG_0}}});
    for (int i = 0; i < 3; i++) exp_q.push_back({3'b000, 3'b001 << i});
    exp_q.push_back({3'b000, 3'b001});
    cyc = 0; ndone = 0; ngnt = 0; last_done = 0; pg = '0;
    req = 3'b111;
    while (ndone < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (gnt_o != '0 && pg == '0) begin
        ngnt++;
        if (ngnt > 1) begin
          tests_run++;
          if (cyc - last_done < GAP) begin
            fails++;
            $display("FAIL rr_gap: grant %0d came %0d cycles after done, expected >= %0d",
                     ngnt, cyc - last_done, GAP);
          end
        end
        if (ngnt == 4) req = '0;
      end
      if (done_o != '0) begin
        ndone++;
        last_done = cyc;
      end
      pg = gnt_o;
    end
    tests_run++;
    if (ndone != 4) begin
      fails++;
      $display("FAIL rr_frames: got %0d frames, expected 4", ndone);
    end
    wait_idle("rr_idle", GAP + 5);
  endtask

  task automatic test_ack_error();
    busy_delay = 1;
    busy_len   = 6;
    err_at     = 2;
    run_frame("ack_err", 1, {SEG_DASH, SEG_5, SEG_4, SEG_9}, 1'b1);
    err_at = -1;
    run_frame("ack_clean", 1, {SEG_8, SEG_7, SEG_6, SEG_5}, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    never_busy = 1'b1;
    digits[31:0] = {SEG_BLANK, SEG_BLANK, SEG_DASH, SEG_DASH};
    exp_gnt_q.push_back({3'b001, {SEG_BLANK, SEG_BLANK, SEG_DASH, SEG_DASH}});
    exp_q.push_back({3'b001, 3'b001});
    req = 3'b001;
    n = 0;
    while (gnt_o !== 3'b001 && n < 5) begin
      @(negedge clk);
      n++;
    end
    req = '0;
    n = 0;
    while (drv_strobe_o === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n != TMO) begin
      fails++;
      $display("FAIL timeout_strobe: strobe high %0d cycles, expected %0d", n, TMO);
    end
    tests_run++;
    if (done_o !== 3'b001 || err_o !== 3'b001) begin
      fails++;
      $display("FAIL timeout_pulse: got done=%b err=%b when strobe dropped, expected 001/001", done_o, err_o);
    end
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n != GAP || state_o !== 2'd0) begin
      fails++;
      $display("FAIL timeout_gap: idle after %0d cycles (state=%0d), expected %0d cycles, state 0", n, state_o, GAP);
    end
    never_busy = 1'b0;
  endtask

  task automatic test_data_stability();
    int n;
    bit bad;
    logic [31:0] pat_a, pat_b;
    pat_a = {SEG_1, SEG_2, SEG_3, SEG_4};
    pat_b = {SEG_9, SEG_8, SEG_7, SEG_6};
    busy_delay = 2;
    busy_len   = 5;
    err_at     = -1;
    bad        = 1'b0;
    digits[95:64] = pat_a;
    exp_gnt_q.push_back({3'b100, pat_a});
    exp_q.push_back({3'b000, 3'b100});
    req = 3'b100;
    n = 0;
    while (gnt_o !== 3'b100 && n < 5) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    digits[95:64] = pat_b;
    req = '0;
    n = 0;
    while (done_o === '0 && n < 200) begin
      if (drv_digits_o !== pat_a) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bad || drv_digits_o !== pat_a) begin
      fails++;
      $display("FAIL stability_digits: drv_digits changed (now %h), expected %h held", drv_digits_o, pat_a);
    end
    tests_run++;
    if (done_o !== 3'b100) begin
      fails++;
      $display("FAIL stability_done: got done=%b, expected 100", done_o);
    end
    wait_idle("stability_idle", GAP + 5);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int d0;
    logic [31:0] pat0, pat1;
    pat0 = {SEG_0, SEG_0, SEG_7, SEG_7};
    pat1 = {SEG_3, SEG_3, SEG_1, SEG_1};
    busy_delay = 1;
    busy_len   = 40;
    err_at     = -1;
    digits[31:0] = pat0;
    exp_gnt_q.push_back({3'b001, pat0});
    req = 3'b001;
    n = 0;
    while (state_o !== 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (state_o !== 2'd2) begin
      fails++;
      $display("FAIL midreset_reach: state=%0d, expected WAIT_DONE (2)", state_o);
    end
    d0 = done_pulses;
    porb = 1'b0;
    req  = '0;
    #1;
    tests_run++;
    if ({gnt_o, done_o, err_o, drv_digits_o, drv_strobe_o, busy_o, state_o} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: gnt=%b done=%b err=%b digits=%h strobe=%b busy=%b state=%0d, expected all 0",
               gnt_o, done_o, err_o, drv_digits_o, drv_strobe_o, busy_o, state_o);
    end
    repeat (3) @(negedge clk);
    digits[63:32] = pat1;
    digits[95:64] = {SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH};
    req = 3'b110;
    exp_gnt_q.push_back({3'b010, pat1});
    exp_q.push_back({3'b000, 3'b010});
    porb = 1'b1;
    @(negedge clk);
    tests_run++;
    if (gnt_o !== 3'b010) begin
      fails++;
      $display("FAIL midreset_first_grant: got gnt=%b, expected 010", gnt_o);
    end
    tests_run++;
    if (done_pulses != d0) begin
      fails++;
      $display("FAIL midreset_no_done: got %0d done pulses across reset, expected 0", done_pulses - d0);
    end
    req = '0;
    busy_len = 4;
    n = 0;
    while (done_o === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    wait_idle("midreset_idle", GAP + 5);
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_round_robin();
    test_ack_error();
    test_timeout();
    test_data_stability();
    test_reset_mid_frame();
    repeat (5) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_done: %0d expected frame results never seen", exp_q.size());
    end
    tests_run++;
    if (exp_gnt_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_grant: %0d expected grants never seen", exp_gnt_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
